// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: pointer geometry and
// Gray/binary conversion helpers used by both the read and write controllers.
package fifo_pkg;

    localparam int ADDR_DATA_DEF = 3;
    localparam int PTR_W         = ADDR_DATA_DEF + 1;

    // Helpers work on a 32-bit container; callers zero-extend and truncate.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Shared by the read side (write pointer) and the write side (read pointer).
module fifo_ptr_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("fifo_ptr_sync: SYNC_STAGES must be at least 2");
    end

    logic [WIDTH-1:0] stages [SYNC_STAGES];

    // NOTE: the chain is a handful of flops, not a memory, so every stage is
    // reset; non-blocking assignments make each stage take the previous
    // stage's old value, which is what creates the shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointer, Gray copy for
// the write domain, synchronized write pointer, empty flag, level, underflow.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_DATA   = ADDR_DATA_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 RD_CLK,
    input  logic                 RD_RST,
    input  logic                 RD_inc,
    input  logic [ADDR_DATA:0]   WR_PTR,
    output logic                 RD_empty,
    output logic [ADDR_DATA-1:0] RD_addr,
    output logic [ADDR_DATA:0]   RD_PTR_g,
    output logic [ADDR_DATA:0]   RD_level,
    output logic                 RD_underflow
);

    localparam int PW = ADDR_DATA + 1;

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("fifo_read_ctrl: DATA_WIDTH must be positive");
    end

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] wr_sync;
    logic          pop;

    fifo_ptr_sync #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk   (RD_CLK),
        .rst_n (RD_RST),
        .d     (WR_PTR),
        .q     (wr_sync)
    );

    assign pop         = RD_inc && !RD_empty;
    assign rd_ptr_next = rd_ptr + PW'(pop);

    // Gray copy is registered from the next binary value so it changes on the
    // same edge as the binary pointer and is glitch-free into the write domain.
    always_ff @(posedge RD_CLK or negedge RD_RST) begin
        if (!RD_RST) begin
            rd_ptr       <= '0;
            RD_PTR_g     <= '0;
            RD_underflow <= 1'b0;
        end else begin
            rd_ptr       <= rd_ptr_next;
            RD_PTR_g     <= PW'(bin2gray(32'(rd_ptr_next)));
            RD_underflow <= RD_inc && RD_empty;
        end
    end

    assign RD_empty = (wr_sync == RD_PTR_g);
    assign RD_addr  = rd_ptr[ADDR_DATA-1:0];
    assign RD_level = PW'(gray2bin(32'(wr_sync))) - rd_ptr;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl at default geometry (8 entries,
// two-stage synchronizer): table of directed vectors plus corner sequences.
module tb_fifo_read_ctrl;

    logic       clk;
    logic       rst;
    logic       rd_inc;
    logic [3:0] wr_ptr;
    logic       rd_empty;
    logic [2:0] rd_addr;
    logic [3:0] rd_ptr_g;
    logic [3:0] rd_level;
    logic       rd_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    fifo_read_ctrl #(
        .DATA_WIDTH  (8),
        .ADDR_DATA   (3),
        .SYNC_STAGES (2)
    ) dut (
        .RD_CLK       (clk),
        .RD_RST       (rst),
        .RD_inc       (rd_inc),
        .WR_PTR       (wr_ptr),
        .RD_empty     (rd_empty),
        .RD_addr      (rd_addr),
        .RD_PTR_g     (rd_ptr_g),
        .RD_level     (rd_level),
        .RD_underflow (rd_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       inc;
        logic [3:0] wr;
        int         edges;
        logic       empty;
        logic [2:0] addr;
        logic [3:0] g;
        logic [3:0] level;
        logic       uf;
    } vec_t;

    vec_t vecs [17];

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic empty, input logic [2:0] addr,
                             input logic [3:0] g, input logic [3:0] level, input logic uf);
        check({tag, " empty"},     32'(rd_empty),     32'(empty));
        check({tag, " addr"},      32'(rd_addr),      32'(addr));
        check({tag, " ptr_g"},     32'(rd_ptr_g),     32'(g));
        check({tag, " level"},     32'(rd_level),     32'(level));
        check({tag, " underflow"}, 32'(rd_underflow), 32'(uf));
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    logic [3:0] drain_g [8];
    logic [3:0] exp_ptr;
    logic [3:0] wr_bin;

    initial begin
        //        inc   wr       edges empty addr  g        level   uf
        vecs[0]  = '{1'b0, 4'b0001, 1, 1'b1, 3'd0, 4'b0000, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0001, 1, 1'b0, 3'd0, 4'b0000, 4'd1, 1'b0};
        vecs[2]  = '{1'b1, 4'b0001, 1, 1'b1, 3'd1, 4'b0001, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 4'b0001, 1, 1'b1, 3'd1, 4'b0001, 4'd0, 1'b1};
        vecs[4]  = '{1'b0, 4'b1100, 1, 1'b1, 3'd1, 4'b0001, 4'd0, 1'b0};
        vecs[5]  = '{1'b0, 4'b1100, 1, 1'b0, 3'd1, 4'b0001, 4'd7, 1'b0};
        vecs[6]  = '{1'b1, 4'b1100, 1, 1'b0, 3'd2, 4'b0011, 4'd6, 1'b0};
        vecs[7]  = '{1'b1, 4'b1100, 1, 1'b0, 3'd3, 4'b0010, 4'd5, 1'b0};
        vecs[8]  = '{1'b1, 4'b1100, 1, 1'b0, 3'd4, 4'b0110, 4'd4, 1'b0};
        vecs[9]  = '{1'b1, 4'b1100, 1, 1'b0, 3'd5, 4'b0111, 4'd3, 1'b0};
        // pop while the write pointer advances by one (bin 8 -> 9)
        vecs[10] = '{1'b1, 4'b1101, 1, 1'b0, 3'd6, 4'b0101, 4'd2, 1'b0};
        vecs[11] = '{1'b0, 4'b1101, 2, 1'b0, 3'd6, 4'b0101, 4'd3, 1'b0};
        vecs[12] = '{1'b1, 4'b1101, 1, 1'b0, 3'd7, 4'b0100, 4'd2, 1'b0};
        vecs[13] = '{1'b1, 4'b1101, 1, 1'b0, 3'd0, 4'b1100, 4'd1, 1'b0};
        vecs[14] = '{1'b1, 4'b1101, 1, 1'b1, 3'd1, 4'b1101, 4'd0, 1'b0};
        vecs[15] = '{1'b1, 4'b1101, 1, 1'b1, 3'd1, 4'b1101, 4'd0, 1'b1};
        vecs[16] = '{1'b0, 4'b1101, 1, 1'b1, 3'd1, 4'b1101, 4'd0, 1'b0};

        drain_g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                    4'b0111, 4'b0101, 4'b0100, 4'b1100};

        // Asynchronous reset, before any clock edge has occurred
        rst    = 1'b1;
        rd_inc = 1'b0;
        wr_ptr = 4'b0000;
        #1;
        rst = 1'b0;
        #1;
        check_all("reset", 1'b1, 3'd0, 4'b0000, 4'd0, 1'b0);
        step(2);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            rd_inc = vecs[i].inc;
            wr_ptr = vecs[i].wr;
            step(vecs[i].edges);
            check_all($sformatf("vec%0d", i), vecs[i].empty, vecs[i].addr,
                      vecs[i].g, vecs[i].level, vecs[i].uf);
        end

        // Full drain of 8 entries from a fresh reset
        rd_inc = 1'b0;
        wr_ptr = 4'b0000;
        pulse_reset();
        step(1);
        wr_ptr = 4'b1100;
        step(1);
        check("drain pre level", 32'(rd_level), 32'd0);
        step(1);
        check("drain full level", 32'(rd_level), 32'd8);
        check("drain full empty", 32'(rd_empty), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_inc = 1'b1;
            step(1);
            check($sformatf("drain%0d ptr_g", i), 32'(rd_ptr_g), 32'(drain_g[i]));
            check($sformatf("drain%0d addr", i), 32'(rd_addr), (i + 1) % 8);
            check($sformatf("drain%0d level", i), 32'(rd_level), 32'(7 - i));
        end
        check("drain end empty", 32'(rd_empty), 32'd1);
        step(1);
        check("drain underflow", 32'(rd_underflow), 32'd1);
        check("drain ptr hold", 32'(rd_ptr_g), 32'b1100);
        rd_inc = 1'b0;
        step(1);
        check("drain underflow clear", 32'(rd_underflow), 32'd0);

        // Streaming across the pointer wrap: one write and one pop per cycle
        exp_ptr = 4'd8;
        wr_bin  = 4'd11;
        wr_ptr  = to_gray(wr_bin);
        step(2);
        check("wrap pre level", 32'(rd_level), 32'd3);
        for (int i = 0; i < 20; i++) begin
            wr_bin  = wr_bin + 4'd1;
            wr_ptr  = to_gray(wr_bin);
            rd_inc  = 1'b1;
            step(1);
            exp_ptr = exp_ptr + 4'd1;
            check($sformatf("wrap%0d ptr_g", i), 32'(rd_ptr_g), 32'(to_gray(exp_ptr)));
            check($sformatf("wrap%0d addr", i), 32'(rd_addr), 32'(exp_ptr[2:0]));
            check($sformatf("wrap%0d level", i), 32'(rd_level), 32'd2);
            check($sformatf("wrap%0d empty", i), 32'(rd_empty), 32'd0);
        end

        // Mid-operation reset with five entries pending
        rd_inc = 1'b0;
        wr_bin = exp_ptr + 4'd5;
        wr_ptr = to_gray(wr_bin);
        step(2);
        check("midrst pre level", 32'(rd_level), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check_all("midrst", 1'b1, 3'd0, 4'b0000, 4'd0, 1'b0);
        #1;
        rst = 1'b1;
        step(1);
        check("midrst post1 empty", 32'(rd_empty), 32'd1);
        step(1);
        // read pointer restarts at 0, so the level equals the write pointer
        check("midrst post2 level", 32'(rd_level), 32'(wr_bin));
        check("midrst post2 empty", 32'(rd_empty), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller of the asynchronous FIFO, running entirely in the read clock domain. It owns the read pointer and its Gray-coded copy, synchronizes the write-side Gray pointer into the read domain, and produces the empty flag, fill level and underflow indication. It is the counterpart of the write-side controller and drives the read address of the shared FIFO memory.

## Interface
- DATA_WIDTH, 8, data width of the FIFO memory; carried for consistency, not used internally
- ADDR_DATA, 3, memory address width; depth = 2^ADDR_DATA; pointers are ADDR_DATA+1 bits
- SYNC_STAGES, 2, flop stages in the write-pointer synchronizer; minimum 2

- RD_CLK  input  1  read-domain clock; single clock of the block
- RD_RST  input  1  reset, asynchronous, active-low
- RD_inc  input  1  read request; pops one entry when RD_empty=0
- WR_PTR  input  ADDR_DATA+1  write pointer, Gray-coded, from the write domain (unsynchronized)
- RD_empty  output  1  FIFO empty, as seen from the read domain
- RD_addr  output  ADDR_DATA  memory read address
- RD_PTR_g  output  ADDR_DATA+1  registered Gray-coded read pointer, sent to the write domain
- RD_level  output  ADDR_DATA+1  entries available, 0..2^ADDR_DATA
- RD_underflow  output  1  one-cycle pulse: RD_inc was asserted while empty

## Operation
- Binary read pointer RD_PTR (ADDR_DATA+1 bits); RD_addr = RD_PTR[ADDR_DATA-1:0]; wraps modulo 2^(ADDR_DATA+1).
- Pop: on RD_CLK rising edge with RD_inc=1 and RD_empty=0, RD_PTR increments by 1. RD_PTR_g is registered from the next binary value (g = b ^ (b>>1)), so it updates on the same edge and never glitches.
- RD_inc=1 with RD_empty=1: no pointer change; RD_underflow=1 for the following cycle.
- WR_PTR passes through a SYNC_STAGES-deep flop chain; the last stage is wr_sync.
- RD_empty = (wr_sync == RD_PTR_g); combinational from registers.
- RD_level = gray2bin(wr_sync) - RD_PTR, modulo 2^(ADDR_DATA+1); RD_level==0 iff RD_empty=1.
- Read data is taken combinationally from memory at RD_addr; the entry is valid whenever RD_empty=0.
- Reset: RD_PTR, RD_PTR_g, all sync flops, RD_underflow = 0; hence RD_empty=1, RD_addr=0, RD_level=0. Reset mid-operation discards all state immediately; pending entries are lost.

## Timing
- Pop latency: RD_addr/RD_PTR_g/RD_empty/RD_level reflect a pop directly after the accepting edge.
- Write visibility: a WR_PTR change sampled at edge k appears in wr_sync after edge k+SYNC_STAGES-1 (2 edges total at default); RD_empty deasserts and RD_level rises then.
- Empty is pessimistic: it may stay asserted up to SYNC_STAGES cycles after data is written; never deasserts falsely.
- Simultaneous pop and incoming write: pop applies at the edge; new write becomes visible per sync latency; RD_level reflects both.
- Back-to-back pops allowed every cycle while RD_empty=0.
- RD_underflow: asserted the cycle after the offending edge, exactly one cycle per offending request.

## Structure
- Shared package fifo_pkg: ADDR_DATA default, gray2bin/bin2gray functions, pointer width constant.
- Sub-module fifo_ptr_sync: parameterized width and SYNC_STAGES, async active-low reset to 0; reused by the write side for RD_PTR_g.

## Test plan
- Reset (ADDR_DATA=3): RD_RST=0 -> RD_empty=1, RD_addr=0, RD_PTR_g=0000, RD_level=0, RD_underflow=0, asynchronously.
- Single entry: WR_PTR=0001 -> RD_empty=0, RD_level=1 after 2 edges; one RD_inc -> RD_addr=1, RD_PTR_g=0001, RD_empty=1.
- Full drain: WR_PTR=1100 (8 entries) -> RD_level=8; 8 pops -> RD_PTR_g 0001,0011,0010,0110,0111,0101,0100,1100; RD_empty=1 after 8th; 9th RD_inc -> RD_underflow pulse, pointer stays 1100.
- Wrap: stream 20 writes/pops -> RD_PTR 15->0 with RD_PTR_g 1000->0000, RD_addr 7->0; no spurious empty/level.
- Simultaneous: level 3, pop while WR_PTR advances by one -> level 2 after edge, 3 after 2 further edges.
- Mid-op reset: level 5, RD_RST pulsed low -> all outputs return to reset values immediately; after release with WR_PTR stable, level reappears after 2 edges.
